// File: rtl/led_sequencer_pkg.sv
// Shared types and constants for the LED pattern engine: mode and direction encodings,
// speed-select indices and the speed indicator helper.
package led_sequencer_pkg;

    typedef enum logic [1:0] {
        MODE_ROTL  = 2'b00,
        MODE_ROTR  = 2'b01,
        MODE_PONG  = 2'b10,
        MODE_FLASH = 2'b11
    } mode_e;

    typedef enum logic {
        DIR_LEFT  = 1'b0,
        DIR_RIGHT = 1'b1
    } dir_e;

    localparam logic [1:0] SPEED_0 = 2'd0;
    localparam logic [1:0] SPEED_1 = 2'd1;
    localparam logic [1:0] SPEED_2 = 2'd2;
    localparam logic [1:0] SPEED_3 = 2'd3;

    function automatic logic [3:0] speed_onehot(input logic [1:0] speed);
        return 4'b0001 << speed;
    endfunction

endpackage

// File: rtl/led_sequencer_prescaler.sv
// Free-running step prescaler: counts up to a selectable terminal count and pulses o_tick
// (combinationally) on the cycle the counter wraps.
module tick_prescaler #(
    parameter int NB_COUNT = 32
) (
    input  logic                clock,
    input  logic                i_reset,
    input  logic                i_run,
    input  logic                i_clear,
    input  logic [NB_COUNT-1:0] i_limit,
    output logic                o_tick
);

    logic [NB_COUNT-1:0] count_q, count_d;
    logic                at_limit;

    // >= rather than == so a switch to a shorter period never waits for a full wrap
    assign at_limit = (count_q >= i_limit);

    always_comb begin
        count_d = count_q;
        o_tick  = 1'b0;
        if (i_clear) begin
            count_d = '0;
        end else if (i_run) begin
            if (at_limit) begin
                count_d = '0;
                o_tick  = 1'b1;
            end else begin
                count_d = count_q + NB_COUNT'(1);
            end
        end
    end

    always_ff @(posedge clock or posedge i_reset) begin
        if (i_reset) count_q <= '0;
        else         count_q <= count_d;
    end

endmodule

// File: rtl/led_sequencer.sv
// LED pattern engine: prescaled step tick advances an NB_LEDS-wide pattern in rotate-left,
// rotate-right, ping-pong or flash mode; all outputs are registered.
module led_sequencer
    import led_sequencer_pkg::*;
#(
    parameter int          NB_LEDS  = 4,
    parameter int          NB_COUNT = 32,
    parameter int unsigned LIMIT_0  = 2**26-1,
    parameter int unsigned LIMIT_1  = 2**25-1,
    parameter int unsigned LIMIT_2  = 2**24-1,
    parameter int unsigned LIMIT_3  = 2**23-1
) (
    input  logic               clock,
    input  logic               i_reset,
    input  logic               i_run,
    input  logic [1:0]         i_speed,
    input  logic [1:0]         i_mode,
    output logic [NB_LEDS-1:0] o_leds,
    output logic [3:0]         o_led_r,
    output logic               o_tick
);

    mode_e               mode_q, mode_d;
    dir_e                dir_q, dir_d;
    logic                phase_q, phase_d;
    logic [NB_LEDS-1:0]  pat_q, pat_d;
    logic [NB_LEDS-1:0]  leds_q, leds_d;
    logic                tick_q, tick_d;
    logic [3:0]          led_r_q;
    logic [NB_COUNT-1:0] limit;
    logic                mode_chg;
    logic                step;

    assign mode_chg = (mode_e'(i_mode) != mode_q);

    always_comb begin
        limit = NB_COUNT'(LIMIT_0);
        case (i_speed)
            SPEED_0: limit = NB_COUNT'(LIMIT_0);
            SPEED_1: limit = NB_COUNT'(LIMIT_1);
            SPEED_2: limit = NB_COUNT'(LIMIT_2);
            SPEED_3: limit = NB_COUNT'(LIMIT_3);
            default: limit = NB_COUNT'(LIMIT_0);
        endcase
    end

    // A mode change clears the counter so the new pattern starts on a full period
    tick_prescaler #(.NB_COUNT(NB_COUNT)) u_prescaler (
        .clock   (clock),
        .i_reset (i_reset),
        .i_run   (i_run),
        .i_clear (mode_chg),
        .i_limit (limit),
        .o_tick  (step)
    );

    always_comb begin
        mode_d  = mode_e'(i_mode);
        dir_d   = dir_q;
        phase_d = phase_q;
        pat_d   = pat_q;
        tick_d  = 1'b0;
        if (mode_chg) begin
            pat_d   = NB_LEDS'(1);
            dir_d   = DIR_LEFT;
            phase_d = 1'b0;
        end else if (step) begin
            tick_d = 1'b1;
            case (mode_q)
                MODE_ROTL: pat_d = {pat_q[NB_LEDS-2:0], pat_q[NB_LEDS-1]};
                MODE_ROTR: pat_d = {pat_q[0], pat_q[NB_LEDS-1:1]};
                MODE_PONG: begin
                    // Turn around and move in the same tick so an end LED is lit only once
                    if (dir_q == DIR_LEFT) begin
                        if (pat_q[NB_LEDS-1]) begin
                            dir_d = DIR_RIGHT;
                            pat_d = pat_q >> 1;
                        end else begin
                            pat_d = pat_q << 1;
                        end
                    end else begin
                        if (pat_q[0]) begin
                            dir_d = DIR_LEFT;
                            pat_d = pat_q << 1;
                        end else begin
                            pat_d = pat_q >> 1;
                        end
                    end
                end
                MODE_FLASH: phase_d = ~phase_q;
                default: ;
            endcase
        end
        leds_d = (mode_d == MODE_FLASH) ? {NB_LEDS{phase_d}} : pat_d;
    end

    always_ff @(posedge clock or posedge i_reset) begin
        if (i_reset) begin
            mode_q  <= MODE_ROTL;
            dir_q   <= DIR_LEFT;
            phase_q <= 1'b0;
            pat_q   <= NB_LEDS'(1);
            leds_q  <= NB_LEDS'(1);
            tick_q  <= 1'b0;
            led_r_q <= 4'b0001;
        end else begin
            mode_q  <= mode_d;
            dir_q   <= dir_d;
            phase_q <= phase_d;
            pat_q   <= pat_d;
            leds_q  <= leds_d;
            tick_q  <= tick_d;
            led_r_q <= speed_onehot(i_speed);
        end
    end

    assign o_leds  = leds_q;
    assign o_led_r = led_r_q;
    assign o_tick  = tick_q;

endmodule

// File: tb/tb_led_sequencer.sv
// Bench for led_sequencer: directed pattern sequences plus randomized stimulus checked
// against an LED-index based reference model.
module tb_led_sequencer;

    localparam int N = 4;

    logic         clock = 1'b0;
    logic         i_reset;
    logic         i_run;
    logic [1:0]   i_speed;
    logic [1:0]   i_mode;
    logic [N-1:0] o_leds;
    logic [3:0]   o_led_r;
    logic         o_tick;

    always #5 clock = ~clock;

    led_sequencer #(
        .NB_LEDS(N), .NB_COUNT(32),
        .LIMIT_0(7), .LIMIT_1(5), .LIMIT_2(3), .LIMIT_3(1)
    ) dut (
        .clock   (clock),
        .i_reset (i_reset),
        .i_run   (i_run),
        .i_speed (i_speed),
        .i_mode  (i_mode),
        .o_leds  (o_leds),
        .o_led_r (o_led_r),
        .o_tick  (o_tick)
    );

    int n_chk = 0;
    int n_err = 0;
    int lim [4] = '{7, 5, 3, 1};

    // Model: lit LED index and step direction (+1/-1), flash phase, prescaler count
    int           m_mode, m_pos, m_dir, m_phase, m_cnt;
    logic [N-1:0] e_leds;
    logic [3:0]   e_ledr;
    logic         e_tick;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [N-1:0] m_leds();
        logic [N-1:0] v;
        if (m_mode == 3) return m_phase != 0 ? {N{1'b1}} : {N{1'b0}};
        v = '0;
        v[m_pos] = 1'b1;
        return v;
    endfunction

    task automatic m_reset();
        m_mode = 0; m_pos = 0; m_dir = 1; m_phase = 0; m_cnt = 0;
        e_tick = 1'b0; e_ledr = 4'b0001; e_leds = m_leds();
    endtask

    task automatic m_advance();
        case (m_mode)
            0: m_pos = (m_pos + 1) % N;
            1: m_pos = (m_pos + N - 1) % N;
            2: begin
                if (m_pos + m_dir < 0 || m_pos + m_dir >= N) m_dir = -m_dir;
                m_pos = m_pos + m_dir;
            end
            default: m_phase = 1 - m_phase;
        endcase
    endtask

    task automatic m_clock();
        e_ledr = 4'b0001 << i_speed;
        e_tick = 1'b0;
        if (int'(i_mode) != m_mode) begin
            m_mode = int'(i_mode); m_pos = 0; m_dir = 1; m_phase = 0; m_cnt = 0;
        end else if (i_run) begin
            if (m_cnt >= lim[i_speed]) begin
                m_cnt = 0;
                e_tick = 1'b1;
                m_advance();
            end else begin
                m_cnt++;
            end
        end
        e_leds = m_leds();
    endtask

    task automatic chk_all(input string tag);
        chk($sformatf("%s.leds", tag), 32'(o_leds), 32'(e_leds));
        chk($sformatf("%s.tick", tag), 32'(o_tick), 32'(e_tick));
        chk($sformatf("%s.led_r", tag), 32'(o_led_r), 32'(e_ledr));
    endtask

    task automatic cyc(input string tag);
        m_clock();
        @(posedge clock);
        #1;
        chk_all(tag);
    endtask

    task automatic wait_tick(input string tag, input logic [N-1:0] exp, input int max);
        for (int k = 0; k < max; k++) begin
            cyc(tag);
            if (o_tick) begin
                chk($sformatf("%s.step", tag), 32'(o_leds), 32'(exp));
                return;
            end
        end
        chk($sformatf("%s.timeout", tag), 32'd0, 32'd1);
    endtask

    task automatic do_reset(input string tag);
        #3;
        i_reset = 1'b1;
        #1;
        m_reset();
        chk_all({tag, ".async"});
        @(posedge clock);
        #1;
        chk_all({tag, ".held"});
        i_reset = 1'b0;
    endtask

    initial begin
        logic [N-1:0] p2 [4] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
        logic [N-1:0] p3 [7] = '{4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0010};
        logic [N-1:0] frozen;

        i_reset = 1'b1; i_run = 1'b0; i_speed = 2'd0; i_mode = 2'd0;
        m_reset();
        #12;
        chk_all("por");
        @(posedge clock);
        #1;
        i_reset = 1'b0;

        // rotate left at fastest speed
        i_run = 1'b1; i_speed = 2'd3; i_mode = 2'd0;
        foreach (p2[k]) wait_tick("rotl", p2[k], 4);

        // ping-pong at speed 2
        i_mode = 2'd2; i_speed = 2'd2;
        cyc("pong.chg");
        chk("pong.start", 32'(o_leds), 32'h1);
        foreach (p3[k]) wait_tick("pong", p3[k], 6);

        // mid-run async reset
        cyc("pre_rst");
        do_reset("rst");

        // flash, then back to rotate right
        i_mode = 2'd3;
        cyc("flash.chg");
        chk("flash.start", 32'(o_leds), 32'h0);
        wait_tick("flash", 4'b1111, 6);
        wait_tick("flash", 4'b0000, 6);
        i_mode = 2'd1;
        cyc("rotr.chg");
        chk("rotr.start", 32'(o_leds), 32'h1);
        wait_tick("rotr", 4'b1000, 6);
        wait_tick("rotr", 4'b0100, 6);

        // speed 0 with counter at 6, then jump to fastest speed
        i_speed = 2'd0;
        for (int k = 0; k < 20 && m_cnt != 6; k++) cyc("spd0");
        chk("spd.cnt6", 32'(m_cnt), 32'd6);
        chk("spd.ledr0", 32'(o_led_r), 32'h1);
        i_speed = 2'd3;
        cyc("spd3");
        chk("spd.tick", 32'(o_tick), 32'h1);
        chk("spd.ledr3", 32'(o_led_r), 32'h8);

        // freeze for 20 clocks, then resume
        cyc("pre_hold");
        frozen = e_leds;
        i_run = 1'b0;
        for (int k = 0; k < 20; k++) begin
            cyc("hold");
            chk("hold.leds", 32'(o_leds), 32'(frozen));
        end
        i_run = 1'b1;
        for (int k = 0; k < 8; k++) cyc("resume");

        // randomized stimulus
        for (int k = 0; k < 500; k++) begin
            if ($urandom_range(0, 39) == 0) i_mode = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 14) == 0) i_speed = 2'($urandom_range(0, 3));
            i_run = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 149) == 0) do_reset("rnd_rst");
            else cyc("rnd");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end

endmodule
